// File: rtl/sat_alu_pkg.sv
// Shared constants and helpers for the WISC saturating add/sub datapath.
package sat_alu_pkg;

  localparam logic MODE_FULL   = 1'b0;
  localparam logic MODE_PACKED = 1'b1;

  // Bit positions inside the {N,Z,V} flag vectors.
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 0;

  // Largest positive two's-complement value of a w-bit field.
  function automatic logic [63:0] sat_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit field.
  function automatic logic [63:0] sat_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_addsub_pipe_cla_group.sv
// One carry-lookahead group; carry-in can be overridden to start a new lane.
module cla_group #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  logic         kill_i,
  input  logic         kval_i,
  output logic         p_o,
  output logic         g_o,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic         c0;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] c;

  assign c0 = kill_i ? kval_i : cin_i;
  assign p  = a_i ^ b_i;
  assign g  = a_i & b_i;

  // Prefix lookahead: every internal carry is derived directly from c0.
  always_comb begin
    logic gp;
    logic pp;
    gp = 1'b0;
    pp = 1'b1;
    c  = '0;
    for (int unsigned k = 0; k < W; k++) begin
      c[k] = gp | (pp & c0);
      gp   = g[k] | (p[k] & gp);
      pp   = pp & p[k];
    end
    p_o    = pp;
    g_o    = gp;
    cout_o = gp | (pp & c0);
  end

  assign sum_o = p ^ c;

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage saturating adder/subtractor with full-width and packed-lane modes
// and the architectural N/Z/V flag register.
module sat_addsub_pipe
  import sat_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned GROUP_W = 4,
  parameter int unsigned LANE_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             mode,
  input  logic [2:0]       flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             N,
  output logic             Z,
  output logic             V
);

  localparam int unsigned NG  = WIDTH / GROUP_W;
  localparam int unsigned NL  = WIDTH / LANE_W;
  localparam int unsigned GPL = (LANE_W / GROUP_W == 0) ? 1 : LANE_W / GROUP_W;

  localparam logic [WIDTH-1:0]  SAT_POS  = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0]  SAT_NEG  = WIDTH'(sat_neg(WIDTH));
  localparam logic [LANE_W-1:0] LSAT_POS = LANE_W'(sat_pos(LANE_W));
  localparam logic [LANE_W-1:0] LSAT_NEG = LANE_W'(sat_neg(LANE_W));

  if ((WIDTH % GROUP_W) != 0 || (WIDTH % LANE_W) != 0 || (LANE_W % GROUP_W) != 0) begin : g_bad_cfg
    $error("sat_addsub_pipe: GROUP_W and LANE_W must divide WIDTH, GROUP_W must divide LANE_W");
  end

  // Stage 1 registers
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_sub_q;
  logic             s1_mode_q;
  logic [2:0]       s1_fwe_q;

  // Stage 2 registers
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic [2:0]       s2_fval_q;
  logic [2:0]       s2_fwe_q;

  logic [2:0]       flags_q;

  logic             s1_ready;
  logic             s2_ready;

  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic [NG:0]      gcin;
  logic [NG-1:0]    grp_p_unused;
  logic [NG-1:0]    grp_g_unused;
  logic [WIDTH-1:0] pres;
  logic             ovf_full;

  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic [2:0]       fval_d;
  logic [2:0]       fwe_d;

  assign s2_ready = ~s2_valid_q | out_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign in_ready = s1_ready;

  assign opb     = s1_sub_q ? ~s1_b_q : s1_b_q;
  assign gcin[0] = s1_sub_q;

  // Groups ripple through cout; group p/g are not needed at this level.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam bit LSTART = (gi != 0) && ((gi % GPL) == 0);
    cla_group #(.W(GROUP_W)) u_grp (
      .a_i    (s1_a_q[gi*GROUP_W +: GROUP_W]),
      .b_i    (opb[gi*GROUP_W +: GROUP_W]),
      .cin_i  (gcin[gi]),
      .kill_i (LSTART && (s1_mode_q == MODE_PACKED)),
      .kval_i (s1_sub_q),
      .p_o    (grp_p_unused[gi]),
      .g_o    (grp_g_unused[gi]),
      .sum_o  (sum[gi*GROUP_W +: GROUP_W]),
      .cout_o (gcin[gi+1])
    );
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane
    localparam int unsigned HI = l * LANE_W + LANE_W - 1;
    logic lovf;
    assign lovf = (s1_a_q[HI] == opb[HI]) && (sum[HI] != s1_a_q[HI]);
    assign pres[l*LANE_W +: LANE_W] = lovf ? (sum[HI] ? LSAT_POS : LSAT_NEG)
                                           : sum[l*LANE_W +: LANE_W];
  end

  assign ovf_full = (s1_a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);

  // Saturate, select mode and form the flag values that S2 will carry.
  always_comb begin
    res_d  = pres;
    cout_d = 1'b0;
    fval_d = '0;
    fwe_d  = '0;
    if (s1_mode_q == MODE_FULL) begin
      res_d         = ovf_full ? (sum[WIDTH-1] ? SAT_POS : SAT_NEG) : sum;
      cout_d        = gcin[NG];
      fval_d[FLG_N] = res_d[WIDTH-1];
      fval_d[FLG_Z] = (res_d == '0);
      fval_d[FLG_V] = ovf_full;
      fwe_d         = s1_fwe_q;
    end
  end

  // Stage 1: capture the operation on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sub_q   <= 1'b0;
      s1_mode_q  <= MODE_FULL;
      s1_fwe_q   <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= a;
        s1_b_q    <= b;
        s1_sub_q  <= sub;
        s1_mode_q <= mode;
        s1_fwe_q  <= flag_we;
      end
    end
  end

  // Stage 2: register the result; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      s2_fval_q  <= '0;
      s2_fwe_q   <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q  <= res_d;
        cout_q    <= cout_d;
        s2_fval_q <= fval_d;
        s2_fwe_q  <= fwe_d;
      end
    end
  end

  // Flag register: enabled bits commit when the result leaves S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      flags_q <= (flags_q & ~s2_fwe_q) | (s2_fval_q & s2_fwe_q);
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign N         = flags_q[FLG_N];
  assign Z         = flags_q[FLG_Z];
  assign V         = flags_q[FLG_V];

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Scoreboard bench for sat_addsub_pipe with a behavioural arithmetic model.
module tb_sat_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  flag_we = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        cout;
  logic        N, Z, V;

  int unsigned checks = 0;
  int unsigned failures = 0;
  bit          rand_en = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic [2:0]  fv;
    logic [2:0]  we;
  } exp_t;

  exp_t       q[$];
  logic [2:0] mflags = '0;

  sat_addsub_pipe #(.WIDTH(16), .GROUP_W(4), .LANE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .mode(mode), .flag_we(flag_we),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .N(N), .Z(Z), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed integer arithmetic clamped to the representable range.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic s, input logic m, input logic [2:0] we);
    exp_t e;
    int   r, la, lb;
    bit   ovf;
    e.res = '0; e.cout = 1'b0; e.fv = '0; e.we = '0;
    if (!m) begin
      r   = s ? ($signed(av) - $signed(bv)) : ($signed(av) + $signed(bv));
      ovf = (r > 32767) || (r < -32768);
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      e.res  = 16'(r);
      e.cout = s ? (av >= bv) : ((32'(av) + 32'(bv)) > 32'h0000FFFF);
      e.fv   = {e.res[15], (e.res == 16'h0000), ovf};
      e.we   = we;
    end else begin
      for (int l = 0; l < 4; l++) begin
        la = int'(av[4*l +: 4]); if (la > 7) la -= 16;
        lb = int'(bv[4*l +: 4]); if (lb > 7) lb -= 16;
        r  = s ? la - lb : la + lb;
        if (r > 7) r = 7;
        if (r < -8) r = -8;
        e.res[4*l +: 4] = 4'(r);
      end
    end
    return e;
  endfunction

  // Monitor: flag check every cycle, result check on each output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        chk("flags_nzv", {29'd0, N, Z, V}, {29'd0, mflags});
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("result", {16'd0, result}, {16'd0, e.res});
            chk("cout", {31'd0, cout}, {31'd0, e.cout});
            mflags = (mflags & ~e.we) | (e.fv & e.we);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic s,
                      input logic m, input logic [2:0] we);
    int unsigned n = 0;
    @(negedge clk);
    a = av; b = bv; sub = s; mode = m; flag_we = we; in_valid = 1'b1;
    if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
      #1;
    end
    q.push_back(model(av, bv, s, m, we));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input logic [15:0] er, input logic ec);
    @(negedge clk); #1;
    chk("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_result", {16'd0, result}, {16'd0, er});
    chk("latency_cout", {31'd0, cout}, {31'd0, ec});
  endtask

  task automatic drain();
    int unsigned n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_flags(input logic n, input logic z, input logic v);
    #3;
    chk("flags_const", {29'd0, N, Z, V}, {29'd0, n, z, v});
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corner [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7F18};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] r0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_flags", {29'd0, N, Z, V}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Positive overflow saturates
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'b111);
    lat_check(16'h7FFF, 1'b0);
    drain(); chk_flags(1'b0, 1'b0, 1'b1);

    // Negative overflow, then exact zero
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 3'b111);
    lat_check(16'h8000, 1'b1);
    drain(); chk_flags(1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0005, 1'b1, 1'b0, 3'b111);
    lat_check(16'h0000, 1'b1);
    drain(); chk_flags(1'b0, 1'b1, 1'b0);

    // Packed lanes, flags untouched
    send(16'h7F18, 16'h1181, 1'b0, 1'b1, 3'b111);
    lat_check(16'h7099, 1'b0);
    drain(); chk_flags(1'b0, 1'b1, 1'b0);

    // Partial flag write keeps the unselected bits
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 3'b111);
    drain(); chk_flags(1'b1, 1'b0, 1'b1);
    send(16'h0003, 16'h0003, 1'b1, 1'b0, 3'b010);
    drain(); chk_flags(1'b1, 1'b1, 1'b1);

    // Backpressure: two ops fill the pipe, third waits
    @(negedge clk); out_ready = 1'b0;
    send(16'h1000, 16'h0234, 1'b0, 1'b0, 3'b000);
    send(16'h4000, 16'h4000, 1'b0, 1'b1, 3'b000);
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b1; mode = 1'b0; flag_we = 3'b000; in_valid = 1'b1;
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    r0 = result;
    @(negedge clk); #1;
    chk("stall_result_stable", {16'd0, result}, {16'd0, r0});
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(16'h0100, 16'h0200, 1'b1, 1'b0, 3'b000);
    drain(); chk_flags(1'b1, 1'b1, 1'b1);

    // Async reset with both stages occupied
    @(negedge clk); out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 3'b111);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 3'b111);
    #2;
    rst_n = 1'b0;
    q.delete();
    mflags = '0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_flags", {29'd0, N, Z, V}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 3'b111);
    lat_check(16'h2345, 1'b0);
    drain(); chk_flags(1'b0, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and gaps
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(pick(), pick(), 1'($urandom), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_en = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
